// File: rtl/tetrix_pkg.sv
// rtl/tetrix_pkg.sv - board geometry, colour width and arbiter state type shared by the board scan path
package tetrix_pkg;

   localparam int CELL_SHIFT   = 4;
   localparam int BOARD_X0     = 320;
   localparam int BOARD_Y0     = 140;
   localparam int BOARD_COLS   = 10;
   localparam int BOARD_ROWS   = 20;
   localparam int BOARD_ADDR_W = 8;
   localparam int COLOR_W      = 6;
   localparam int VBLANK_Y     = 600;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RENDER = 2'd1,
      ST_GAME   = 2'd2
   } arb_state_t;

   // Constant multiply built from shifted partial sums so no multiplier is inferred.
   function automatic logic [15:0] mul_const(input logic [15:0] a, input int k);
      logic [15:0] acc;
      acc = '0;
      for (int i = 0; i < 16; i++) begin
         if (k[i]) acc = acc + (a << i);
      end
      return acc;
   endfunction

endpackage

// File: rtl/board_addr_calc.sv
// rtl/board_addr_calc.sv - maps the scan position to the board cell address, board flag and fetch strobe
module board_addr_calc #(
   parameter int CELL_SHIFT = tetrix_pkg::CELL_SHIFT,
   parameter int BOARD_X0   = tetrix_pkg::BOARD_X0,
   parameter int BOARD_Y0   = tetrix_pkg::BOARD_Y0,
   parameter int BOARD_COLS = tetrix_pkg::BOARD_COLS,
   parameter int BOARD_ROWS = tetrix_pkg::BOARD_ROWS,
   parameter int ADDR_W     = tetrix_pkg::BOARD_ADDR_W
) (
   input  logic [10:0]       i_px_x,
   input  logic [9:0]        i_px_y,
   output logic              o_fetch_due,
   output logic              o_in_board,
   output logic [ADDR_W-1:0] o_addr
);
   import tetrix_pkg::*;

   localparam logic [10:0] LP_X0 = 11'(BOARD_X0);
   localparam logic [10:0] LP_X1 = 11'(BOARD_X0 + (BOARD_COLS << CELL_SHIFT));
   localparam logic [9:0]  LP_Y0 = 10'(BOARD_Y0);
   localparam logic [9:0]  LP_Y1 = 10'(BOARD_Y0 + (BOARD_ROWS << CELL_SHIFT));

   logic [10:0] w_dx;
   logic [9:0]  w_dy;
   logic        w_in_x;
   logic        w_in_y;
   logic [15:0] w_col;
   logic [15:0] w_row;

   assign w_dx   = i_px_x - LP_X0;
   assign w_dy   = i_px_y - LP_Y0;
   assign w_in_x = (i_px_x >= LP_X0) && (i_px_x < LP_X1);
   assign w_in_y = (i_px_y >= LP_Y0) && (i_px_y < LP_Y1);
   assign w_col  = 16'(w_dx >> CELL_SHIFT);
   assign w_row  = 16'(w_dy >> CELL_SHIFT);

   assign o_in_board  = w_in_x && w_in_y;
   assign o_fetch_due = o_in_board && (w_dx[CELL_SHIFT-1:0] == '0);
   assign o_addr      = ADDR_W'(mul_const(w_row, BOARD_COLS) + w_col);

endmodule

// File: rtl/board_scan_arbiter.sv
// rtl/board_scan_arbiter.sv - shares the board RAM between VGA cell fetch (priority) and game req/ack access
// Optional: TETRIX_VBLANK_WRITE_EN restricts game writes to vertical blanking.
module board_scan_arbiter #(
   parameter int CELL_SHIFT = tetrix_pkg::CELL_SHIFT,
   parameter int BOARD_X0   = tetrix_pkg::BOARD_X0,
   parameter int BOARD_Y0   = tetrix_pkg::BOARD_Y0,
   parameter int BOARD_COLS = tetrix_pkg::BOARD_COLS,
   parameter int BOARD_ROWS = tetrix_pkg::BOARD_ROWS,
   parameter int ADDR_W     = tetrix_pkg::BOARD_ADDR_W,
   parameter int DATA_W     = tetrix_pkg::COLOR_W
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [10:0]       i_px_x,
   input  logic [9:0]        i_px_y,
   output logic [DATA_W-1:0] o_cell_color,
   output logic              o_in_board,
   input  logic              i_gl_req,
   input  logic              i_gl_we,
   input  logic [ADDR_W-1:0] i_gl_addr,
   input  logic [DATA_W-1:0] i_gl_wdata,
   output logic              o_gl_ack,
   output logic              o_gl_rvalid,
   output logic [DATA_W-1:0] o_gl_rdata,
   output logic              o_mem_en,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic [DATA_W-1:0] i_mem_rdata
);
   import tetrix_pkg::*;

   localparam logic [ADDR_W-1:0] LP_CELLS = ADDR_W'(BOARD_COLS * BOARD_ROWS);

   logic              w_fetch_due;
   logic              w_in_board;
   logic [ADDR_W-1:0] w_cell_addr;
   logic              w_gl_inrange;
   logic              w_wr_block;
   arb_state_t        w_state;

   logic              r_run;
   logic              r_ack_last;
   logic              r_tag_vld;
   logic              r_tag_game;
   logic              r_tag_rd;
   logic              r_tag_oob;
   logic [DATA_W-1:0] r_color;
   logic              r_inb1;
   logic              r_inb2;

   board_addr_calc #(
      .CELL_SHIFT (CELL_SHIFT),
      .BOARD_X0   (BOARD_X0),
      .BOARD_Y0   (BOARD_Y0),
      .BOARD_COLS (BOARD_COLS),
      .BOARD_ROWS (BOARD_ROWS),
      .ADDR_W     (ADDR_W)
   ) u_addr_calc (
      .i_px_x      (i_px_x),
      .i_px_y      (i_px_y),
      .o_fetch_due (w_fetch_due),
      .o_in_board  (w_in_board),
      .o_addr      (w_cell_addr)
   );

   assign w_gl_inrange = (i_gl_addr < LP_CELLS);

`ifdef TETRIX_VBLANK_WRITE_EN
   assign w_wr_block = i_gl_we && (i_px_y < 10'(VBLANK_Y));
`else
   assign w_wr_block = 1'b0;
`endif

   // Reset gates the combinational grant so the RAM port is quiet while held in reset.
   always_comb begin
      w_state = ST_IDLE;
      if (!i_rst_n)
         w_state = ST_IDLE;
      else if (w_fetch_due)
         w_state = ST_RENDER;
      else if (i_gl_req && r_run && !w_wr_block && !r_ack_last)
         w_state = ST_GAME;
   end

   assign o_gl_ack    = (w_state == ST_GAME);
   assign o_mem_en    = (w_state == ST_RENDER) || ((w_state == ST_GAME) && w_gl_inrange);
   assign o_mem_we    = (w_state == ST_GAME) && i_gl_we && w_gl_inrange;
   assign o_mem_wdata = o_mem_we ? i_gl_wdata : '0;
   assign o_mem_addr  = (w_state == ST_RENDER) ? w_cell_addr :
                        (w_state == ST_GAME)   ? i_gl_addr   : '0;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_run      <= 1'b0;
         r_ack_last <= 1'b0;
         r_tag_vld  <= 1'b0;
         r_tag_game <= 1'b0;
         r_tag_rd   <= 1'b0;
         r_tag_oob  <= 1'b0;
         r_color    <= '0;
         r_inb1     <= 1'b0;
         r_inb2     <= 1'b0;
      end else begin
         r_run      <= 1'b1;
         r_ack_last <= o_gl_ack;
         r_tag_vld  <= (w_state != ST_IDLE);
         r_tag_game <= (w_state == ST_GAME);
         r_tag_rd   <= !i_gl_we;
         r_tag_oob  <= !w_gl_inrange;
         r_inb1     <= w_in_board;
         r_inb2     <= r_inb1;
         if (r_tag_vld && !r_tag_game)
            r_color <= i_mem_rdata;
      end
   end

   assign o_gl_rvalid  = r_tag_vld && r_tag_game && r_tag_rd;
   assign o_gl_rdata   = (o_gl_rvalid && !r_tag_oob) ? i_mem_rdata : '0;
   assign o_in_board   = r_inb2;
   assign o_cell_color = r_inb2 ? r_color : '0;

endmodule

// File: doc/board_scan_arbiter.md
# board_scan_arbiter

Shares the single-port Tetris board RAM between VGA scan-out and game logic. Every cycle it derives the board cell under the current pixel from the scan counters. It fetches that cell's colour with absolute priority and serves game-logic read/write requests in the free cycles, using a req/ack handshake. It sits between the VGA timing counters, the board RAM and the game FSM, and feeds the 6-bit colour into the pixel mux.

## Interface
Parameters:
- CELL_SHIFT, 4: cell edge = 2^CELL_SHIFT pixels (16).
- BOARD_X0, 320: first board pixel column.
- BOARD_Y0, 140: first board pixel row.
- BOARD_COLS, 10: board width in cells.
- BOARD_ROWS, 20: board height in cells.
- ADDR_W, 8: board RAM address width.
- DATA_W, 6: cell colour width.

Ports:
- clk  in  1  pixel clock (50 MHz).
- rst  in  1  reset, asynchronous, active-low.
- px_x  in  11  horizontal scan counter, 0..1039.
- px_y  in  10  vertical scan counter, 0..665.
- cell_color  out  DATA_W  colour for the pixel presented 2 cycles earlier; 0 outside the board.
- in_board  out  1  board-area flag, aligned with cell_color.
- gl_req  in  1  game access request; held with fields stable until gl_ack.
- gl_we  in  1  1 = write, 0 = read.
- gl_addr  in  ADDR_W  cell index, row*BOARD_COLS+col.
- gl_wdata  in  DATA_W  write data.
- gl_ack  out  1  one-cycle pulse in the cycle the access is issued to RAM.
- gl_rvalid  out  1  one-cycle pulse, one cycle after the gl_ack of a read.
- gl_rdata  out  DATA_W  read data, valid with gl_rvalid.
- mem_en, mem_we  out  1  RAM port controls.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data, one cycle after mem_en (synchronous read).

## Operation
- Board area: BOARD_X0 ≤ px_x < BOARD_X0+BOARD_COLS·2^CELL_SHIFT, and the same rule in y. With defaults this is x 320..479, y 140..459.
- Render fetch is issued when px_x is in the board area, px_y is in the board area, and (px_x−BOARD_X0)[CELL_SHIFT-1:0]==0.
  - Address = row·BOARD_COLS + col, with row = (px_y−BOARD_Y0)>>CELL_SHIFT and col = (px_x−BOARD_X0)>>CELL_SHIFT.
  - The multiply is shift-add; no DSP.
- Arbiter states:
  - IDLE: port unused.
  - RENDER: render fetch issued this cycle.
  - GAME: game access issued this cycle.
- Transitions, evaluated every cycle:
  - render fetch due → RENDER;
  - else gl_req, not blocked, and gl_ack not pulsed last cycle → GAME;
  - else IDLE.
- The render fetch always wins. A colliding gl_req waits; with fetches at most 1 in 2^CELL_SHIFT cycles, the wait is ≤1 cycle.
- After every gl_ack there is one mandatory IDLE/RENDER cycle. gl_ack therefore never fires two cycles in a row, and the requester sees ack before re-presenting.
- A one-bit owner tag registered with mem_en routes mem_rdata:
  - tag = RENDER → load the colour register;
  - tag = GAME read → drive gl_rdata and pulse gl_rvalid.
- The colour register holds its value between fetches. cell_color is forced to 0 whenever the delayed in_board is 0.
- gl_addr ≥ BOARD_COLS·BOARD_ROWS:
  - write: acked, mem_we kept 0;
  - read: acked, then gl_rvalid with gl_rdata = 0.

## Timing
- Render path: px_x/px_y sampled in cycle t; mem_en in t (combinational from counters); mem_rdata in t+1; cell_color/in_board registered at t+2. The pixel mux must delay sync by 2 cycles.
- Game write: gl_ack pulses in the same cycle as mem_en=mem_we=1.
- Game read: gl_ack in cycle t; gl_rvalid/gl_rdata in t+1.
- Reset (asynchronous assert, any time):
  - all outputs go to 0, the state goes to IDLE and the tag is cleared;
  - an in-flight access is dropped with no ack and no rvalid;
  - the requester re-presents the access after deassertion.
- First possible gl_ack is 1 cycle after rst deasserts.

## Configuration
- TETRIX_VBLANK_WRITE_EN defined: game writes are blocked while px_y < 600, so they are granted only in vertical blanking (y 600..665). This gives tear-free updates. Game reads are unaffected.
- Macro not defined: game writes are granted in any free cycle.

## Structure
- Package tetrix_pkg:
  - board geometry constants (BOARD_COLS, BOARD_ROWS, CELL_SHIFT, BOARD_X0, BOARD_Y0);
  - colour width;
  - arbiter state enum (IDLE, RENDER, GAME).
- Sub-module board_addr_calc (combinational): px_x, px_y → fetch_due, in_board, cell address. The arbiter FSM, tag pipeline and colour register stay in board_scan_arbiter.

## Test plan
- RAM[0]=6'h15, scan px_x=320, px_y=140 → mem_en=1, mem_addr=0 at t; cell_color=6'h15 and in_board=1 at t+2; colour held through px_x=335.
- px_x=479→480 on px_y=200 → in_board falls 2 cycles after px_x=480; cell_color=0.
- gl_req write, addr 199, data 6'h3F, asserted in the same cycle as the fetch at px_x=336 → RENDER first, gl_ack next cycle; a later readback of addr 199 gives gl_rvalid with 6'h3F.
- Back-to-back gl_req reads of addr 5 and 6 → gl_ack pulses separated by ≥1 cycle; each gl_rvalid is 1 cycle after its ack.
- gl_req write, addr 200 → gl_ack, mem_we stays 0; RAM unchanged.
- With TETRIX_VBLANK_WRITE_EN, a write raised at px_y=300 → no ack until px_y=600, acked there; reset asserted mid-wait → no ack, all outputs 0.
